// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared constants and types for sync_fifo_param            |
// | Read-mode constants, occupancy state encoding, address-width helper  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_param_if : data/handshake/status bundle of the FIFO        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0]         din_i;
    logic                     wr_en_i;
    logic                     rd_en_i;
    logic [WIDTH-1:0]         dout_o;
    logic                     full_o;
    logic                     empty_o;
    logic                     almost_full_o;
    logic                     almost_empty_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     overflow_o;
    logic                     underflow_o;

    modport master (
        output din_i, wr_en_i, rd_en_i,
        input  dout_o, full_o, empty_o, almost_full_o, almost_empty_o,
        input  count_o, overflow_o, underflow_o
    );

    modport slave (
        input  din_i, wr_en_i, rd_en_i,
        output dout_o, full_o, empty_o, almost_full_o, almost_empty_o,
        output count_o, overflow_o, underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem : WIDTH x DEPTH storage, one sync write, one async read     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic              clk,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]  i_wr_data,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]  o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately never reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_param : single-clock FIFO with count, programmable flags,  |
// | overflow/underflow pulses and standard or FWFT read                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  wire logic         clk_i,
    input  wire logic         reset_i,
    sync_fifo_param_if.slave  bus
);
    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   w_wr_ptr_next;
    logic [ADDR_W:0]   w_rd_ptr_next;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    occ_state_t        r_state;
    occ_state_t        w_state_next;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_unf;
    logic [WIDTH-1:0]  w_mem_rdata;
    logic [WIDTH-1:0]  w_dout;

    // Extra pointer MSB makes the difference an exact 0..DEPTH occupancy.
    assign w_count = r_wr_ptr - r_rd_ptr;

    always_comb begin
        w_rd_accept   = bus.rd_en_i & (r_state != OCC_EMPTY);
        w_wr_accept   = bus.wr_en_i & ((r_state != OCC_FULL) | w_rd_accept);
        w_wr_ptr_next = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_accept};
        w_rd_ptr_next = r_rd_ptr + {{ADDR_W{1'b0}}, w_rd_accept};
        w_count_next  = w_wr_ptr_next - w_rd_ptr_next;
        w_state_next  = r_state;
        case (r_state)
            OCC_EMPTY: begin
                if (w_wr_accept) w_state_next = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (w_wr_accept && !w_rd_accept && (w_count == CNT_W'(DEPTH - 1)))
                    w_state_next = OCC_FULL;
                else if (w_rd_accept && !w_wr_accept && (w_count == CNT_W'(1)))
                    w_state_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (w_rd_accept && !w_wr_accept) w_state_next = OCC_PARTIAL;
            end
            default: w_state_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_state  <= OCC_EMPTY;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_state  <= w_state_next;
            r_full   <= (w_state_next == OCC_FULL);
            r_empty  <= (w_state_next == OCC_EMPTY);
            r_af     <= (w_count_next >= CNT_W'(AF_LEVEL));
            r_ae     <= (w_count_next <= CNT_W'(AE_LEVEL));
            r_ovf    <= bus.wr_en_i & (r_state == OCC_FULL) & ~w_rd_accept;
            r_unf    <= bus.rd_en_i & (r_state == OCC_EMPTY);
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk_i),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (bus.din_i),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign w_dout = w_mem_rdata;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            always_ff @(posedge clk_i) begin
                if (reset_i)          r_dout <= '0;
                else if (w_rd_accept) r_dout <= w_mem_rdata;
            end
            assign w_dout = r_dout;
        end
    endgenerate

    assign bus.dout_o         = w_dout;
    assign bus.full_o         = r_full;
    assign bus.empty_o        = r_empty;
    assign bus.almost_full_o  = r_af;
    assign bus.almost_empty_o = r_ae;
    assign bus.count_o        = w_count;
    assign bus.overflow_o     = r_ovf;
    assign bus.underflow_o    = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo_param : directed vector table for the standard-read     |
// | FIFO plus a hand sequence for the FWFT variant                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] din;
        logic       rd;
        int         cnt;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
        dut0 (.clk_i(clk), .reset_i(rst0), .bus(bus0.slave));

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
        dut1 (.clk_i(clk), .reset_i(rst1), .bus(bus1.slave));

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic wr, input logic [7:0] din,
                                input logic rd, input int cnt, input logic [7:0] dout,
                                input logic ovf, input logic unf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.rd = rd;
        v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic step1(input logic wr, input logic [7:0] din, input logic rd);
        bus1.wr_en_i = wr;
        bus1.din_i   = din;
        bus1.rd_en_i = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.wr_en_i = 1'b0; bus0.rd_en_i = 1'b0; bus0.din_i = '0;
        bus1.wr_en_i = 1'b0; bus1.rd_en_i = 1'b0; bus1.din_i = '0;

        // Standard-read table: fill, drain, refill, overflow, write+read on full,
        // drain, underflow with write, reset mid-operation.
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 8'(k), 0, k, 8'h00, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 8'h00, 1, 8 - k, 8'(k), 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 8'(k), 0, k, 8'h08, 0, 0);
        add(0, 1, 8'hAA, 0, 8, 8'h08, 1, 0);
        add(0, 0, 8'h00, 0, 8, 8'h08, 0, 0);
        add(0, 1, 8'hBB, 1, 8, 8'h01, 0, 0);
        for (int k = 2; k <= 8; k++) add(0, 0, 8'h00, 1, 9 - k, 8'(k), 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'hBB, 0, 0);
        add(0, 1, 8'h55, 1, 1, 8'hBB, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'hBB, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h55, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h55, 0, 1);
        for (int k = 1; k <= 5; k++) add(0, 1, 8'(8'h60 + k), 0, k, 8'h55, 0, 0);
        add(1, 1, 8'h77, 0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            rst0         = vecs[i].rst;
            bus0.wr_en_i = vecs[i].wr;
            bus0.din_i   = vecs[i].din;
            bus0.rd_en_i = vecs[i].rd;
            @(posedge clk);
            #1;
            chk("count",        i, int'(bus0.count_o),        vecs[i].cnt);
            chk("empty",        i, int'(bus0.empty_o),        int'(vecs[i].cnt == 0));
            chk("full",         i, int'(bus0.full_o),         int'(vecs[i].cnt == DEPTH));
            chk("almost_full",  i, int'(bus0.almost_full_o),  int'(vecs[i].cnt >= AF));
            chk("almost_empty", i, int'(bus0.almost_empty_o), int'(vecs[i].cnt <= AE));
            chk("overflow",     i, int'(bus0.overflow_o),     int'(vecs[i].ovf));
            chk("underflow",    i, int'(bus0.underflow_o),    int'(vecs[i].unf));
            chk("dout",         i, int'(bus0.dout_o),         int'(vecs[i].dout));
        end
        rst0 = 1'b0;
        bus0.wr_en_i = 1'b0; bus0.rd_en_i = 1'b0;

        // FWFT: head visible one edge after the write, no rd_en needed.
        step1(0, 8'h00, 0);
        chk("fwft_rst_empty", 0, int'(bus1.empty_o), 1);
        rst1 = 1'b0;
        step1(1, 8'h3C, 0);
        chk("fwft_empty", 1, int'(bus1.empty_o), 0);
        chk("fwft_dout",  1, int'(bus1.dout_o),  8'h3C);
        chk("fwft_count", 1, int'(bus1.count_o), 1);
        step1(0, 8'h00, 0);
        chk("fwft_hold",  2, int'(bus1.dout_o),  8'h3C);
        step1(0, 8'h00, 1);
        chk("fwft_pop_empty", 3, int'(bus1.empty_o), 1);
        chk("fwft_pop_count", 3, int'(bus1.count_o), 0);

        // 16 write/read pairs through a one-deep occupancy wrap both pointers.
        step1(1, 8'h10, 0);
        for (int i = 0; i < 16; i++) begin
            chk("fwft_wrap_dout", 4 + i, int'(bus1.dout_o), 8'h10 + i);
            step1(1, 8'(8'h11 + i), 1);
            chk("fwft_wrap_count", 4 + i, int'(bus1.count_o), 1);
        end
        chk("fwft_last_dout", 20, int'(bus1.dout_o), 8'h20);
        step1(0, 8'h00, 1);
        chk("fwft_end_empty", 21, int'(bus1.empty_o), 1);
        chk("fwft_end_unf",   21, int'(bus1.underflow_o), 0);
        step1(0, 8'h00, 1);
        chk("fwft_unf", 22, int'(bus1.underflow_o), 1);
        step1(0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
